// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and alignment rule for dmem_banked.
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
        return (size == 2'b11) || (size == SZ_HALF && ofs[0]) || (size == SZ_WORD && ofs != 2'b00);
    endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: big-endian byte-lane store merge and load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_ofs,
    input  logic        i_sign_ext,
    output logic [31:0] o_merged,
    output logic [31:0] o_loaded
);
    logic [4:0]  w_sh;
    logic [31:0] w_mask;
    logic [15:0] w_field;

    // Lane 0 is the most significant byte, so the shift is taken from the inverted offset.
    always_comb begin
        w_sh     = i_size == SZ_BYTE ? {~i_ofs, 3'b000} : i_size == SZ_HALF ? {~i_ofs[1], 4'b0000} : 5'd0;
        w_mask   = i_size == SZ_BYTE ? 32'h0000_00FF << w_sh : i_size == SZ_HALF ? 32'h0000_FFFF << w_sh : 32'hFFFF_FFFF;
        o_merged = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
        w_field  = 16'((i_word & w_mask) >> w_sh);
        o_loaded = i_size == SZ_BYTE ? {{24{i_sign_ext & w_field[7]}}, w_field[7:0]} :
                   i_size == SZ_HALF ? {{16{i_sign_ext & w_field[15]}}, w_field} : i_word;
    end
endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: wait-stated MEM-stage data memory with req/ready handshake,
// sub-word big-endian access and misalignment faulting.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] INIT_WORD0  = 32'd50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misalign
);
    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);

    // Power-up contents only; rst_n never touches the array.
    logic [31:0] r_mem [DEPTH] = '{0: INIT_WORD0, default: 32'd0};

    state_t                 r_state, w_next;
    logic [3:0]             r_cnt;
    logic                   w_mis, w_access, w_unused;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [31:0]            w_merged, w_loaded;

    assign w_idx    = addr[ADDR_BITS+1:2];
    assign w_mis    = is_misaligned(size, addr[1:0]);
    assign ready    = r_state == DONE;
    assign w_unused = ^addr[31:ADDR_BITS+2];

    dmem_lane_align u_align (
        .i_word     (r_mem[w_idx]),
        .i_wdata    (wdata),
        .i_size     (size),
        .i_ofs      (addr[1:0]),
        .i_sign_ext (sign_ext),
        .o_merged   (w_merged),
        .o_loaded   (w_loaded)
    );

    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        case (r_state)
            IDLE: if (req) begin
                w_next   = (w_mis || WAIT_STATES == 0) ? DONE : WAIT;
                w_access = !w_mis && WAIT_STATES == 0;
            end
            WAIT: begin
                w_access = r_cnt == 4'd0;
                w_next   = w_access ? DONE : WAIT;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            rdata    <= 32'd0;
            misalign <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req)
                r_cnt <= CNT_LOAD;
            else if (r_state == WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == IDLE && req && w_mis) begin
                rdata    <= 32'd0;
                misalign <= 1'b1;
            end else if (w_access) begin
                misalign <= 1'b0;
                if (!we)
                    rdata <= w_loaded;
            end
        end
    end

    always_ff @(posedge clk)
        if (w_access && we)
            r_mem[w_idx] <= w_merged;
endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: table vectors plus random traffic against a byte-array model,
// on two instances (WAIT_STATES = 2 and 0).
module tb_dmem_banked;
    logic        clk = 1'b0;
    logic        rst_n, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        req [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        misalign [2];

    always #5 clk = ~clk;

    dmem_banked #(.ADDR_BITS(8), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata[0]), .ready(ready[0]), .misalign(misalign[0]));
    dmem_banked #(.ADDR_BITS(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata[1]), .ready(ready[1]), .misalign(misalign[1]));

    int checks = 0;
    int failures = 0;
    byte unsigned mb [2][1024];
    logic [31:0] exp_rd [2];

    typedef struct {
        int          d;
        bit          w;
        logic [1:0]  sz;
        bit          se;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          mis;
        int          lat;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return d == 0 ? 2 : 0;
    endfunction

    function automatic bit mis_m(input logic [1:0] sz, input logic [31:0] a);
        int n = 1 << sz;
        return sz == 2'd3 || (a % n) != 0;
    endfunction

    function automatic logic [31:0] load_m(input int d, input logic [1:0] sz, input logic [31:0] a, input bit se);
        int n = 1 << sz;
        int b = int'(a % 1024);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(mb[d][b + k]);
        if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic store_m(input int d, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = 1 << sz;
        int b = int'(a % 1024);
        for (int k = 0; k < n; k++) mb[d][b + k] = 8'(wd >> (8 * (n - 1 - k)));
    endtask

    task automatic access(input int d, input bit w, input logic [1:0] sz, input bit se,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e_rd,
                          input bit e_mis, input int e_lat, input string nm);
        int lat = 0;
        @(negedge clk);
        we = w; size = sz; sign_ext = se; addr = a; wdata = wd; req[d] = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready[d] && lat < 40);
        req[d] = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'(e_lat));
        chk({nm, " rdata"}, rdata[d], e_rd);
        chk({nm, " misalign"}, 32'(misalign[d]), 32'(e_mis));
        @(posedge clk);
    endtask

    task automatic apply(input int d, input bit w, input logic [1:0] sz, input bit se,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e_rd,
                         input bit e_mis, input int e_lat, input string nm);
        if (!e_mis && w) store_m(d, sz, a, wd);
        exp_rd[d] = e_rd;
        access(d, w, sz, se, a, wd, e_rd, e_mis, e_lat, nm);
    endtask

    task automatic model_op(input int d, input bit w, input logic [1:0] sz, input bit se,
                            input logic [31:0] a, input logic [31:0] wd, input string nm);
        bit m = mis_m(sz, a);
        logic [31:0] e = m ? 32'd0 : w ? exp_rd[d] : load_m(d, sz, a, se);
        apply(d, w, sz, se, a, wd, e, m, m ? 1 : ws_of(d) + 1, nm);
    endtask

    initial begin
        vec_t tv[$];
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) mb[d][i] = 8'd0;
            mb[d][3] = 8'd50;
            exp_rd[d] = 32'd0;
            req[d] = 1'b0;
        end
        rst_n = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ready%0d", d), 32'(ready[d]), 32'd0);
            chk($sformatf("reset rdata%0d", d), rdata[d], 32'd0);
            chk($sformatf("reset misalign%0d", d), 32'(misalign[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        tv.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        32'h0000_0032, 1'b0, 3, "lw0"});
        tv.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h10,  32'h8899_AABB, 32'h0000_0032, 1'b0, 3, "sw10"});
        tv.push_back('{0, 1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'hFFFF_FF99, 1'b0, 3, "lb11"});
        tv.push_back('{0, 1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'h0000_0099, 1'b0, 3, "lbu11"});
        tv.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h12,  32'h0000_1234, 32'h0000_0099, 1'b0, 3, "sh12"});
        tv.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h8899_1234, 1'b0, 3, "lw10"});
        tv.push_back('{0, 1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        32'h0000_8899, 1'b0, 3, "lhu10"});
        tv.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h6,   32'h0,        32'h0,         1'b1, 1, "lw6_mis"});
        tv.push_back('{0, 1'b1, 2'd1, 1'b0, 32'h7,   32'h0000_FFFF, 32'h0,         1'b1, 1, "sh7_mis"});
        tv.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h4,   32'h0,        32'h0,         1'b0, 3, "lw4"});
        tv.push_back('{0, 1'b1, 2'd2, 1'b0, 32'h404, 32'hDEAD_BEEF, 32'h0,         1'b0, 3, "sw404"});
        tv.push_back('{0, 1'b0, 2'd2, 1'b0, 32'h4,   32'h0,        32'hDEAD_BEEF, 1'b0, 3, "lw4_wrap"});
        tv.push_back('{0, 1'b0, 2'd3, 1'b0, 32'h8,   32'h0,        32'h0,         1'b1, 1, "sz11_mis"});
        tv.push_back('{0, 1'b0, 2'd1, 1'b1, 32'h6,   32'h0,        32'hFFFF_BEEF, 1'b0, 3, "lh6"});
        tv.push_back('{1, 1'b1, 2'd2, 1'b0, 32'h404, 32'hDEAD_BEEF, 32'h0,         1'b0, 1, "ws0_sw404"});
        tv.push_back('{1, 1'b0, 2'd2, 1'b0, 32'h4,   32'h0,        32'hDEAD_BEEF, 1'b0, 1, "ws0_lw4"});
        tv.push_back('{1, 1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        32'h0000_0032, 1'b0, 1, "ws0_lw0"});
        foreach (tv[i])
            apply(tv[i].d, tv[i].w, tv[i].sz, tv[i].se, tv[i].a, tv[i].wd, tv[i].rd, tv[i].mis, tv[i].lat, tv[i].nm);

        // Reset one cycle into a wait-stated store must abort it.
        @(negedge clk);
        we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hCAFE_F00D; req[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst ready", 32'(ready[0]), 32'd0);
        chk("midrst rdata", rdata[0], 32'd0);
        chk("midrst misalign", 32'(misalign[0]), 32'd0);
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        apply(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 3, "lw20_after_rst");

        for (int i = 0; i < 200; i++) begin
            int d = int'($urandom_range(0, 1));
            bit w = 1'($urandom_range(0, 1));
            logic [1:0] sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            bit se = 1'($urandom_range(0, 1));
            logic [31:0] a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a = a | (32'($urandom_range(0, 7)) << 10);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~(32'((1 << sz) - 1));
            model_op(d, w, sz, se, a, $urandom, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_banked.md
# dmem_banked

Parametrised successor data memory for the MIPS pipeline's MEM stage: configurable depth and wait states, byte/halfword/word loads and stores with sign or zero extension, and misaligned-access detection. Accesses use a req/ready handshake so the hazard unit can stall the pipeline for slow memory. Word width stays 32 bits. Byte order is big-endian, matching the MIPS ISA target.

## Interface
- ADDR_BITS, 8: word-index width; depth = 2^ADDR_BITS words (default 256 words = 1 KB).
- WAIT_STATES, 2: extra cycles per aligned access, 0–15.
- INIT_WORD0, 32'd50: power-up content of word 0. All other words power up 0.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; held with all request inputs stable until ready.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address; word index = addr[ADDR_BITS+1:2]; upper bits ignored, so addresses wrap modulo depth.
- wdata  in  32  store data, right-justified for sub-word stores.
- rdata  out  32  registered load result.
- ready  out  1  one-cycle completion pulse.
- misalign  out  1  qualifies ready; request faulted.

## Operation
- FSM states and transitions:
  - IDLE: on `req`, the request is accepted at that edge.
    - Misaligned request → DONE.
    - Aligned request, WAIT_STATES = 0 → performs the access at the accept edge, then DONE.
    - Aligned request, otherwise → WAIT; counter loaded with WAIT_STATES − 1.
  - WAIT: counter decrements each cycle. The access is performed at the edge where counter = 0, which also moves the FSM to DONE.
  - DONE: ready = 1 for exactly one cycle, then IDLE unconditionally. A new req is never accepted in DONE.
- Misaligned means any of:
  - size = 11.
  - size = 01 with addr[0] ≠ 0.
  - size = 10 with addr[1:0] ≠ 0.
- A misaligned request writes nothing; rdata ← 0; misalign ← 1 at the DONE entry edge.
- Aligned requests set misalign ← 0 at completion.
- Byte lanes (big-endian): addr[1:0] = 0 selects bits [31:24] … addr[1:0] = 3 selects bits [7:0]. For a halfword, addr[1] = 0 selects [31:16] and addr[1] = 1 selects [15:0].
- Store: only the selected lanes are written, from wdata[7:0] (byte) or wdata[15:0] (halfword). Other lanes keep their value. rdata is unchanged by a store.
- Load: the selected lane is right-justified, then extended per sign_ext to 32 bits. For a word load, sign_ext is ignored.
- rdata and misalign hold their value until the next completion.
- Memory array contents are not affected by rst_n. They are set only by initialisation and stores.

## Timing
- Reset values: state IDLE, counter 0, rdata 0, ready 0, misalign 0.
- Accept edge is t0. Completion edge is t0 + WAIT_STATES. ready is high in the cycle after the completion edge.
- Load-to-ready latency is therefore WAIT_STATES + 1 cycles.
- Misaligned requests take 1 cycle regardless of WAIT_STATES.
- Minimum spacing between accepts is WAIT_STATES + 2 cycles, because of the one DONE bubble.
- Requester may drop req or present a new request in the cycle after ready.
- Reset asserted mid-access (IDLE→WAIT in progress, completion edge not yet reached) aborts the access with no write. Outputs go to reset values immediately.
- Dropping req while in WAIT is a protocol violation. The access still completes using the inputs sampled at the completion edge.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum {IDLE, WAIT, DONE}.
  - misalignment check function.
- Sub-module dmem_lane_align (combinational) covers:
  - store merge: old word, wdata, size, addr[1:0] → new word.
  - load extract/extend: word, size, addr[1:0], sign_ext → rdata value.
- Top level holds the array, FSM, counter and output registers.

## Test plan
- Power-up, WAIT_STATES = 2: lw from addr 0x0 → ready in the 3rd cycle after accept, rdata = 0x00000032, misalign = 0.
- sw 0x8899AABB to 0x10, then lb from 0x11 with sign_ext = 1 → 0xFFFFFF99. Same load with sign_ext = 0 → 0x00000099.
- After the above, sh 0x1234 to 0x12, then lw from 0x10 → 0x88991234. Then lhu from 0x10 → 0x00008899.
- lw from 0x6, and sh to 0x7 with wdata 0xFFFF → ready after 1 cycle, misalign = 1, rdata = 0. A following lw from 0x4 returns the unchanged word.
- sw 0xDEADBEEF to 0x404 with ADDR_BITS = 8 → lw from 0x004 returns 0xDEADBEEF (wrap). Repeat with WAIT_STATES = 0: ready arrives 1 cycle after accept.
- Accept sw 0xCAFEF00D to 0x20, assert rst_n = 0 one cycle after accept (WAIT_STATES = 2) → ready/rdata go 0 at once. After release, lw from 0x20 → 0x00000000.
